// File: rtl/regfile_scrub_if.sv
// Register-file bus: two read ports, one write port, clear request and
// scrub status. The master side drives addresses and write data.
interface regfile_scrub_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;
  logic [ADDR_W-1:0] WriteRegister;
  logic [WIDTH-1:0]  WriteData;
  logic              RegWrite;
  logic              Clear;
  logic              Busy;
  logic              WriteDropped;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, Clear,
    input  ReadData1, ReadData2, Busy, WriteDropped
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, Clear,
    output ReadData1, ReadData2, Busy, WriteDropped
  );
endinterface

// File: rtl/regfile_scrub.sv
// Register file (r0 hardwired to zero) with a one-register-per-cycle clear engine.
// Define REGFILE_BYPASS_EN to forward a pending IDLE write to matching read ports.
module regfile_scrub #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic          Clk,
  input  logic          Reset,
  regfile_scrub_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE,
    SCRUB
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pointer;
  logic [WIDTH-1:0]  regs [DEPTH];
  logic              busy;
  logic              write_dropped;

  logic              write_hit;
  logic              write_ok;
  logic              write_drop;
  logic              last_ptr;
  logic [WIDTH-1:0]  read1;
  logic [WIDTH-1:0]  read2;

  // A write to r0 is neither performed nor reported as dropped.
  assign write_hit  = bus.RegWrite && (bus.WriteRegister != '0);
  assign write_ok   = write_hit && (state == IDLE) && !bus.Clear;
  assign write_drop = write_hit && ((state == SCRUB) || bus.Clear);
  assign last_ptr   = (pointer == ADDR_W'(DEPTH - 1));

  // NOTE: the storage array is reset like ordinary flops because reset must
  // zero every register at once; this rules out mapping it onto a RAM macro.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      state         <= IDLE;
      pointer       <= ADDR_W'(1);
      busy          <= 1'b0;
      write_dropped <= 1'b0;
    end else begin
      write_dropped <= write_drop;
      case (state)
        IDLE: begin
          if (bus.Clear) begin
            state   <= SCRUB;
            pointer <= ADDR_W'(1);
            busy    <= 1'b1;
          end else if (write_ok) begin
            regs[bus.WriteRegister] <= bus.WriteData;
          end
        end
        SCRUB: begin
          // Clear requests here are ignored: the sweep neither restarts nor extends.
          regs[pointer] <= '0;
          if (last_ptr) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pointer <= ADDR_W'(1);
          end else begin
            pointer <= pointer + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it holding a value and infer a latch.
  always_comb begin
    read1 = '0;
    read2 = '0;
    if (!busy) begin
      if (bus.ReadRegister1 != '0) read1 = regs[bus.ReadRegister1];
      if (bus.ReadRegister2 != '0) read2 = regs[bus.ReadRegister2];
`ifdef REGFILE_BYPASS_EN
      if (write_ok && (bus.ReadRegister1 == bus.WriteRegister)) read1 = bus.WriteData;
      if (write_ok && (bus.ReadRegister2 == bus.WriteRegister)) read2 = bus.WriteData;
`endif
    end
  end

  assign bus.ReadData1    = read1;
  assign bus.ReadData2    = read2;
  assign bus.Busy         = busy;
  assign bus.WriteDropped = write_dropped;
endmodule

// File: tb/tb_regfile_scrub.sv
// Directed self-checking bench for regfile_scrub: reads/writes, r0, fill,
// clear engine timing, dropped writes, reset mid-scrub and write bypass.
module tb_regfile_scrub;
  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  regfile_scrub_if #(.WIDTH(32), .ADDR_W(5)) bus ();

  regfile_scrub #(.WIDTH(32), .ADDR_W(5)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_reg(input int addr, input logic [31:0] data);
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'(addr);
    bus.WriteData     = data;
    step();
    bus.RegWrite      = 1'b0;
  endtask

  task automatic read_pair(input int a1, input int a2);
    bus.ReadRegister1 = 5'(a1);
    bus.ReadRegister2 = 5'(a2);
    #1;
  endtask

  // Called one step after the edge that started a scrub. Optionally issues a
  // write to r5 or a repeat Clear at given cycles, or asserts Reset and returns.
  task automatic watch_scrub(input int write_at, input int clear_at, input int reset_at,
                             output int cycles);
    logic bad_read;
    bad_read = 1'b0;
    cycles   = 0;
    while (bus.Busy && cycles < 100) begin
      cycles++;
      if (bus.ReadData1 !== 32'd0 || bus.ReadData2 !== 32'd0) bad_read = 1'b1;
      if (cycles == reset_at) begin
        Reset = 1'b1;
        #1;
        break;
      end
      bus.RegWrite      = (cycles == write_at);
      bus.WriteRegister = 5'd5;
      bus.WriteData     = 32'd7;
      bus.Clear         = (cycles == clear_at);
      step();
      check("scrub_drop_pulse", 32'(bus.WriteDropped), 32'(cycles == write_at));
    end
    bus.RegWrite = 1'b0;
    bus.Clear    = 1'b0;
    check("scrub_reads_zero", 32'(bad_read), 32'd0);
  endtask

  initial begin
    int cycles;
    checks            = 0;
    errors            = 0;
    Reset             = 1'b1;
    bus.RegWrite      = 1'b0;
    bus.Clear         = 1'b0;
    bus.WriteRegister = '0;
    bus.WriteData     = '0;
    bus.ReadRegister1 = 5'd2;
    bus.ReadRegister2 = 5'd31;
    #3;
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_drop", 32'(bus.WriteDropped), 32'd0);
    check("reset_rd1", bus.ReadData1, 32'd0);
    check("reset_rd2", bus.ReadData2, 32'd0);
    #9;
    Reset = 1'b0;
    step();

    // Test 1: write 42 then 15 to r2.
    read_pair(2, 2);
    write_reg(2, 32'd42);
    check("t1_w42_rd1", bus.ReadData1, 32'd42);
    check("t1_w42_rd2", bus.ReadData2, 32'd42);
    write_reg(2, 32'd15);
    check("t1_w15_rd1", bus.ReadData1, 32'd15);
    check("t1_w15_rd2", bus.ReadData2, 32'd15);
    read_pair(3, 0);
    check("t1_other_r3", bus.ReadData1, 32'd0);
    check("t1_other_r0", bus.ReadData2, 32'd0);

    // Test 2: disabled write and write to r0.
    read_pair(2, 0);
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = 5'd2;
    bus.WriteData     = 32'd18;
    step();
    check("t2_no_we_r2", bus.ReadData1, 32'd15);
    write_reg(0, 32'd3);
    check("t2_r0_zero", bus.ReadData2, 32'd0);
    check("t2_r0_no_drop", 32'(bus.WriteDropped), 32'd0);

    // Test 3: fill ri = i and read back all pairs.
    for (int i = 1; i < 32; i++) write_reg(i, 32'(i));
    for (int i = 0; i < 32; i++) begin
      read_pair(i, 31 - i);
      check("t3_fill_rd1", bus.ReadData1, 32'(i));
      check("t3_fill_rd2", bus.ReadData2, 32'(31 - i));
    end
    read_pair(3, 4);
    check("t3_alias_r3", bus.ReadData1, 32'd3);
    check("t3_alias_r4", bus.ReadData2, 32'd4);
    check("t3_no_drop", 32'(bus.WriteDropped), 32'd0);

    // Test 4: one-cycle Clear, write to r5 during scrub.
    read_pair(5, 31);
    bus.Clear = 1'b1;
    step();
    bus.Clear = 1'b0;
    check("t4_busy_start", 32'(bus.Busy), 32'd1);
    watch_scrub(3, 0, 0, cycles);
    check("t4_busy_cycles", 32'(cycles), 32'd31);
    check("t4_busy_end", 32'(bus.Busy), 32'd0);
    begin
      logic nonzero;
      nonzero = 1'b0;
      for (int i = 1; i < 32; i++) begin
        read_pair(i, i);
        if (bus.ReadData1 !== 32'd0 || bus.ReadData2 !== 32'd0) nonzero = 1'b1;
      end
      check("t4_all_zero", 32'(nonzero), 32'd0);
    end
    read_pair(5, 5);
    check("t4_r5_zero", bus.ReadData1, 32'd0);

    // Test 5a: Clear and write on the same edge; repeat Clear at cycle 10.
    write_reg(6, 32'd55);
    read_pair(6, 6);
    check("t5_r6_before", bus.ReadData1, 32'd55);
    bus.Clear         = 1'b1;
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd6;
    bus.WriteData     = 32'd9;
    step();
    bus.Clear    = 1'b0;
    bus.RegWrite = 1'b0;
    check("t5_same_edge_drop", 32'(bus.WriteDropped), 32'd1);
    check("t5_same_edge_busy", 32'(bus.Busy), 32'd1);
    watch_scrub(0, 10, 0, cycles);
    check("t5_no_extend", 32'(cycles), 32'd31);
    check("t5_r6_zero", bus.ReadData1, 32'd0);

    // Test 5b: Reset at cycle 15 of a scrub, with upper registers still live.
    write_reg(20, 32'd20);
    write_reg(31, 32'd31);
    read_pair(20, 31);
    check("t5_r20_live", bus.ReadData1, 32'd20);
    check("t5_r31_live", bus.ReadData2, 32'd31);
    bus.Clear = 1'b1;
    step();
    bus.Clear = 1'b0;
    watch_scrub(0, 0, 15, cycles);
    check("t5_reset_cycle", 32'(cycles), 32'd15);
    check("t5_reset_busy", 32'(bus.Busy), 32'd0);
    check("t5_reset_drop", 32'(bus.WriteDropped), 32'd0);
    check("t5_reset_r20", bus.ReadData1, 32'd0);
    check("t5_reset_r31", bus.ReadData2, 32'd0);
    step();
    Reset = 1'b0;
    step();
    check("t5_idle_busy", 32'(bus.Busy), 32'd0);
    write_reg(20, 32'd77);
    check("t5_idle_write", bus.ReadData1, 32'd77);

    // Test 6: write-through forwarding before the edge.
    write_reg(4, 32'h1111_1111);
    read_pair(4, 3);
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd4;
    bus.WriteData     = 32'hDEAD_BEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("t6_bypass_rd1", bus.ReadData1, 32'hDEAD_BEEF);
`else
    check("t6_old_rd1", bus.ReadData1, 32'h1111_1111);
`endif
    check("t6_other_rd2", bus.ReadData2, 32'd0);
    bus.Clear = 1'b1;
    #1;
    check("t6_clear_no_bypass", bus.ReadData1, 32'h1111_1111);
    bus.Clear = 1'b0;
    step();
    bus.RegWrite = 1'b0;
    check("t6_after_edge", bus.ReadData1, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
